editor_campos: RTL and testbench

- Value editor that sits on the other end of the field-pointer FSM in the RTC edit path.
- Consumes the pointer index and up/down button pulses, and holds a BCD shadow copy of the nine editable RTC fields.
- Steps the selected field with per-field wrap limits.
- Issues one write transaction per edit to the RTC bus controller through a req/ack handshake.

---
 rtl/rtc_campos_pkg.sv | 71 +++++++
 rtl/editor_campos_if.sv | 15 +
 rtl/bcd_paso.sv | 30 +++
 rtl/editor_campos.sv | 99 +++++++++
 tb/tb_editor_campos.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_campos_pkg.sv
// Shared definitions for the RTC field editor: field codes, register
// addresses, per-field BCD limits and the editor state encoding.
package rtc_campos_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    EDICION   = 2'd1,
    ESCRITURA = 2'd2
  } estado_t;

  localparam logic [3:0] CAMPO_SEG     = 4'd1;
  localparam logic [3:0] CAMPO_MIN     = 4'd2;
  localparam logic [3:0] CAMPO_HORA    = 4'd3;
  localparam logic [3:0] CAMPO_DIA     = 4'd4;
  localparam logic [3:0] CAMPO_MES     = 4'd5;
  localparam logic [3:0] CAMPO_ANIO    = 4'd6;
  localparam logic [3:0] CAMPO_TSEG    = 4'd7;
  localparam logic [3:0] CAMPO_TMIN    = 4'd8;
  localparam logic [3:0] CAMPO_THORA   = 4'd9;
  localparam int         NUM_CAMPOS    = 9;

  localparam logic [7:0] DIR_SEG   = 8'h21;
  localparam logic [7:0] DIR_MIN   = 8'h22;
  localparam logic [7:0] DIR_HORA  = 8'h23;
  localparam logic [7:0] DIR_DIA   = 8'h24;
  localparam logic [7:0] DIR_MES   = 8'h25;
  localparam logic [7:0] DIR_ANIO  = 8'h26;
  localparam logic [7:0] DIR_TSEG  = 8'h41;
  localparam logic [7:0] DIR_TMIN  = 8'h42;
  localparam logic [7:0] DIR_THORA = 8'h43;

  localparam logic [7:0] LIM_59 = 8'h59;
  localparam logic [7:0] LIM_23 = 8'h23;
  localparam logic [7:0] LIM_31 = 8'h31;
  localparam logic [7:0] LIM_12 = 8'h12;
  localparam logic [7:0] LIM_99 = 8'h99;

  function automatic logic campo_valido(input logic [3:0] c);
    return (c >= CAMPO_SEG) && (c <= CAMPO_THORA);
  endfunction

  function automatic logic [7:0] campo_min(input logic [3:0] c);
    return ((c == CAMPO_DIA) || (c == CAMPO_MES)) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] campo_max(input logic [3:0] c);
    case (c)
      CAMPO_HORA, CAMPO_THORA: return LIM_23;
      CAMPO_DIA:               return LIM_31;
      CAMPO_MES:               return LIM_12;
      CAMPO_ANIO:              return LIM_99;
      default:                 return LIM_59;
    endcase
  endfunction

  function automatic logic [7:0] campo_dir(input logic [3:0] c);
    case (c)
      CAMPO_SEG:   return DIR_SEG;
      CAMPO_MIN:   return DIR_MIN;
      CAMPO_HORA:  return DIR_HORA;
      CAMPO_DIA:   return DIR_DIA;
      CAMPO_MES:   return DIR_MES;
      CAMPO_ANIO:  return DIR_ANIO;
      CAMPO_TSEG:  return DIR_TSEG;
      CAMPO_TMIN:  return DIR_TMIN;
      CAMPO_THORA: return DIR_THORA;
      default:     return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/editor_campos_if.sv
// Write channel from the field editor to the RTC bus controller.
// Handshake: wr_req rises with wr_dir/wr_dato valid and all three hold steady
// until the controller pulses wr_ack for one cycle; the request drops next edge.
interface editor_campos_if #(
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_DIR  = 8
);
  logic                  wr_req;
  logic [ANCHO_DIR-1:0]  wr_dir;
  logic [ANCHO_DATO-1:0] wr_dato;
  logic                  wr_ack;

  modport master (output wr_req, output wr_dir, output wr_dato, input wr_ack);
  modport slave  (input wr_req, input wr_dir, input wr_dato, output wr_ack);
endinterface

// File: rtl/bcd_paso.sv
// Combinational two-digit BCD step with inclusive wrap limits; values outside
// the limits (or with non-decimal digits) snap to min on up and max on down.
module bcd_paso (
  input  logic [7:0] valor_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  input  logic       subir_i,
  output logic [7:0] valor_o
);
  logic [3:0] dec;
  logic [3:0] uni;
  logic       fuera;

  assign dec   = valor_i[7:4];
  assign uni   = valor_i[3:0];
  assign fuera = (dec > 4'd9) || (uni > 4'd9) || (valor_i < min_i) || (valor_i > max_i);

  always_comb begin
    valor_o = valor_i;
    if (subir_i) begin
      if (fuera || (valor_i == max_i)) valor_o = min_i;
      else if (uni == 4'd9)            valor_o = {dec + 4'd1, 4'd0};
      else                             valor_o = {dec, uni + 4'd1};
    end else begin
      if (fuera || (valor_i == min_i)) valor_o = max_i;
      else if (uni == 4'd0)            valor_o = {dec - 4'd1, 4'd9};
      else                             valor_o = {dec, uni - 4'd1};
    end
  end
endmodule

// File: rtl/editor_campos.sv
// RTC field editor: BCD shadow of nine fields, up/down stepping of the field
// under the pointer, and one bus write per edit.
module editor_campos
  import rtc_campos_pkg::*;
#(
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_DIR  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  interr,
  input  logic [3:0]            puntero,
  input  logic                  arriba,
  input  logic                  abajo,
  input  logic                  rd_valid,
  input  logic [3:0]            rd_idx,
  input  logic [ANCHO_DATO-1:0] rd_data,
  editor_campos_if.master       bus,
  output logic [ANCHO_DATO-1:0] valor,
  output logic                  ocupado,
  output estado_t               estado_o
);
  estado_t               estado_q;
  logic [ANCHO_DATO-1:0] sombra_q [NUM_CAMPOS];
  logic                  wr_req_q;
  logic [ANCHO_DIR-1:0]  wr_dir_q;
  logic [ANCHO_DATO-1:0] wr_dato_q;
  logic                  ocupado_q;

  logic [3:0]            sel_ptr;
  logic [3:0]            sel_rd;
  logic                  ptr_ok;
  logic                  rd_ok;
  logic                  pulso;
  logic [ANCHO_DATO-1:0] paso_d;

  // Field codes are 1-based; the shadow array is 0-based.
  assign sel_ptr = puntero - 4'd1;
  assign sel_rd  = rd_idx - 4'd1;
  assign ptr_ok  = campo_valido(puntero);
  assign rd_ok   = campo_valido(rd_idx);
  assign pulso   = arriba ^ abajo;
  assign valor   = ptr_ok ? sombra_q[sel_ptr] : '0;

  bcd_paso u_paso (
    .valor_i (valor),
    .min_i   (campo_min(puntero)),
    .max_i   (campo_max(puntero)),
    .subir_i (arriba),
    .valor_o (paso_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      wr_req_q  <= 1'b0;
      wr_dir_q  <= '0;
      wr_dato_q <= '0;
      ocupado_q <= 1'b0;
      for (int i = 0; i < NUM_CAMPOS; i++) begin
        sombra_q[i] <= ((i == 3) || (i == 4)) ? 8'h01 : 8'h00;
      end
    end else begin
      case (estado_q)
        REPOSO: begin
          if (rd_valid && rd_ok) sombra_q[sel_rd] <= rd_data;
          if (interr) estado_q <= EDICION;
        end
        EDICION: begin
          if (!interr) begin
            estado_q <= REPOSO;
          end else if (pulso && ptr_ok) begin
            sombra_q[sel_ptr] <= paso_d;
            wr_req_q          <= 1'b1;
            wr_dir_q          <= campo_dir(puntero);
            wr_dato_q         <= paso_d;
            ocupado_q         <= 1'b1;
            estado_q          <= ESCRITURA;
          end
        end
        ESCRITURA: begin
          // The write always completes, even if edit mode is left meanwhile.
          if (bus.wr_ack) begin
            wr_req_q  <= 1'b0;
            ocupado_q <= 1'b0;
            estado_q  <= interr ? EDICION : REPOSO;
          end
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

  assign bus.wr_req  = wr_req_q;
  assign bus.wr_dir  = wr_dir_q;
  assign bus.wr_dato = wr_dato_q;
  assign ocupado     = ocupado_q;
  assign estado_o    = estado_q;
endmodule

// File: tb/tb_editor_campos.sv
// Directed bench for editor_campos: readback loads, BCD stepping with wraps,
// write handshake behaviour and asynchronous reset.
module tb_editor_campos;
  import rtc_campos_pkg::*;

  logic       clk;
  logic       reset;
  logic       interr;
  logic [3:0] puntero;
  logic       arriba;
  logic       abajo;
  logic       rd_valid;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
  logic [7:0] valor;
  logic       ocupado;
  estado_t    estado;

  int checks;
  int failures;

  editor_campos_if #(.ANCHO_DATO(8), .ANCHO_DIR(8)) bus ();

  editor_campos #(.ANCHO_DATO(8), .ANCHO_DIR(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .interr   (interr),
    .puntero  (puntero),
    .arriba   (arriba),
    .abajo    (abajo),
    .rd_valid (rd_valid),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .bus      (bus.master),
    .valor    (valor),
    .ocupado  (ocupado),
    .estado_o (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_btn(input logic up, input logic dn);
    arriba = up;
    abajo  = dn;
    tick();
    arriba = 1'b0;
    abajo  = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
  endtask

  task automatic load_rd(input logic [3:0] idx, input logic [7:0] d);
    rd_valid = 1'b1;
    rd_idx   = idx;
    rd_data  = d;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%b exp=0", bus.wr_req); end
    checks++; if (bus.wr_dir !== 8'h00) begin failures++; $display("FAIL reset_wr_dir got=%h exp=00", bus.wr_dir); end
    checks++; if (bus.wr_dato !== 8'h00) begin failures++; $display("FAIL reset_wr_dato got=%h exp=00", bus.wr_dato); end
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    checks++; if (estado !== REPOSO) begin failures++; $display("FAIL reset_estado got=%0d exp=%0d", estado, REPOSO); end
    tick(); tick();
    reset  = 1'b1;
    interr = 1'b1;
    tick();
    checks++; if (estado !== EDICION) begin failures++; $display("FAIL enter_edicion got=%0d exp=%0d", estado, EDICION); end
    puntero = 4'd4; #1;
    checks++; if (valor !== 8'h01) begin failures++; $display("FAIL reset_day got=%h exp=01", valor); end
    puntero = 4'd5; #1;
    checks++; if (valor !== 8'h01) begin failures++; $display("FAIL reset_month got=%h exp=01", valor); end
    puntero = 4'd1; #1;
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL reset_sec got=%h exp=00", valor); end
    puntero = 4'd0; #1;
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL ptr0_valor got=%h exp=00", valor); end
    puntero = 4'd12; #1;
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL ptr12_valor got=%h exp=00", valor); end
    pulse_btn(1'b1, 1'b0);
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL ptr12_no_write got=%b exp=0", bus.wr_req); end
  endtask

  task automatic test_readback_hours();
    interr = 1'b0;
    tick();
    load_rd(4'd3, 8'h23);
    load_rd(4'd11, 8'h55);
    puntero = 4'd3; #1;
    checks++; if (valor !== 8'h23) begin failures++; $display("FAIL rd_load_hours got=%h exp=23", valor); end
    interr = 1'b1;
    tick();
    pulse_btn(1'b1, 1'b0);
    checks++; if (bus.wr_req !== 1'b1) begin failures++; $display("FAIL hours_wr_req got=%b exp=1", bus.wr_req); end
    checks++; if (bus.wr_dir !== 8'h23) begin failures++; $display("FAIL hours_wr_dir got=%h exp=23", bus.wr_dir); end
    checks++; if (bus.wr_dato !== 8'h00) begin failures++; $display("FAIL hours_wrap got=%h exp=00", bus.wr_dato); end
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL hours_shadow got=%h exp=00", valor); end
    checks++; if (ocupado !== 1'b1) begin failures++; $display("FAIL hours_ocupado got=%b exp=1", ocupado); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.wr_req !== 1'b1) begin failures++; $display("FAIL hours_hold cyc=%0d got=%b exp=1", i, bus.wr_req); end
    end
    pulse_ack();
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL hours_ack_req got=%b exp=0", bus.wr_req); end
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL hours_ack_ocupado got=%b exp=0", ocupado); end
    checks++; if (estado !== EDICION) begin failures++; $display("FAIL hours_ack_estado got=%0d exp=%0d", estado, EDICION); end
  endtask

  task automatic test_month_minutes();
    puntero = 4'd5;
    pulse_btn(1'b0, 1'b1);
    checks++; if (bus.wr_dato !== 8'h12) begin failures++; $display("FAIL month_wrap got=%h exp=12", bus.wr_dato); end
    checks++; if (bus.wr_dir !== 8'h25) begin failures++; $display("FAIL month_dir got=%h exp=25", bus.wr_dir); end
    pulse_ack();
    puntero = 4'd2;
    for (int i = 0; i < 9; i++) begin
      pulse_btn(1'b1, 1'b0);
      pulse_ack();
    end
    checks++; if (valor !== 8'h09) begin failures++; $display("FAIL minutes_09 got=%h exp=09", valor); end
    pulse_btn(1'b1, 1'b0);
    checks++; if (bus.wr_dato !== 8'h10) begin failures++; $display("FAIL minutes_carry got=%h exp=10", bus.wr_dato); end
    checks++; if (bus.wr_dir !== 8'h22) begin failures++; $display("FAIL minutes_dir got=%h exp=22", bus.wr_dir); end
    pulse_ack();
    pulse_btn(1'b0, 1'b1);
    checks++; if (bus.wr_dato !== 8'h09) begin failures++; $display("FAIL minutes_borrow got=%h exp=09", bus.wr_dato); end
    pulse_ack();
  endtask

  task automatic test_escritura_ignore();
    puntero = 4'd7;
    pulse_btn(1'b1, 1'b0);
    checks++; if (bus.wr_dato !== 8'h01 || bus.wr_dir !== 8'h41) begin failures++; $display("FAIL tsec_write got=%h/%h exp=41/01", bus.wr_dir, bus.wr_dato); end
    arriba = 1'b1; puntero = 4'd8; rd_valid = 1'b1; rd_idx = 4'd7; rd_data = 8'h33;
    tick();
    arriba = 1'b0; rd_valid = 1'b0;
    tick();
    checks++; if (bus.wr_dir !== 8'h41 || bus.wr_dato !== 8'h01) begin failures++; $display("FAIL busy_stable got=%h/%h exp=41/01", bus.wr_dir, bus.wr_dato); end
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL busy_tmin got=%h exp=00", valor); end
    pulse_ack();
    puntero = 4'd7; #1;
    checks++; if (valor !== 8'h01) begin failures++; $display("FAIL busy_tsec got=%h exp=01", valor); end
    puntero = 4'd8;
    pulse_btn(1'b1, 1'b1);
    checks++; if (bus.wr_req !== 1'b0 || estado !== EDICION) begin failures++; $display("FAIL both_btn got=%b/%0d exp=0/%0d", bus.wr_req, estado, EDICION); end
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL both_btn_val got=%h exp=00", valor); end
    pulse_ack();
    checks++; if (estado !== EDICION || bus.wr_req !== 1'b0) begin failures++; $display("FAIL stray_ack got=%0d/%b exp=%0d/0", estado, bus.wr_req, EDICION); end
  endtask

  task automatic test_interr_drop();
    puntero = 4'd9;
    pulse_btn(1'b0, 1'b1);
    checks++; if (bus.wr_dato !== 8'h23 || bus.wr_dir !== 8'h43) begin failures++; $display("FAIL thour_wrap got=%h/%h exp=43/23", bus.wr_dir, bus.wr_dato); end
    interr = 1'b0;
    tick(); tick();
    checks++; if (bus.wr_req !== 1'b1) begin failures++; $display("FAIL drop_hold got=%b exp=1", bus.wr_req); end
    pulse_ack();
    checks++; if (estado !== REPOSO || bus.wr_req !== 1'b0) begin failures++; $display("FAIL drop_reposo got=%0d/%b exp=%0d/0", estado, bus.wr_req, REPOSO); end
    load_rd(4'd6, 8'h47);
    puntero = 4'd6; #1;
    checks++; if (valor !== 8'h47) begin failures++; $display("FAIL drop_rd_load got=%h exp=47", valor); end
  endtask

  task automatic test_out_of_range();
    load_rd(4'd1, 8'h75);
    interr = 1'b1; puntero = 4'd1;
    tick();
    pulse_btn(1'b1, 1'b0);
    checks++; if (bus.wr_dato !== 8'h00) begin failures++; $display("FAIL oor_up got=%h exp=00", bus.wr_dato); end
    pulse_ack();
    interr = 1'b0;
    tick();
    load_rd(4'd1, 8'h75);
    interr = 1'b1;
    tick();
    pulse_btn(1'b0, 1'b1);
    checks++; if (bus.wr_dato !== 8'h59) begin failures++; $display("FAIL oor_dn got=%h exp=59", bus.wr_dato); end
    pulse_ack();
  endtask

  task automatic test_reset_mid_write();
    puntero = 4'd6;
    pulse_btn(1'b1, 1'b0);
    checks++; if (bus.wr_req !== 1'b1 || bus.wr_dato !== 8'h48) begin failures++; $display("FAIL mid_write got=%b/%h exp=1/48", bus.wr_req, bus.wr_dato); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.wr_req !== 1'b0 || ocupado !== 1'b0) begin failures++; $display("FAIL async_clear got=%b/%b exp=0/0", bus.wr_req, ocupado); end
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL async_year got=%h exp=00", valor); end
    puntero = 4'd4; #1;
    checks++; if (valor !== 8'h01) begin failures++; $display("FAIL async_day got=%h exp=01", valor); end
    puntero = 4'd3; #1;
    checks++; if (valor !== 8'h00) begin failures++; $display("FAIL async_hours got=%h exp=00", valor); end
    checks++; if (estado !== REPOSO) begin failures++; $display("FAIL async_estado got=%0d exp=%0d", estado, REPOSO); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; interr = 1'b0; puntero = 4'd0; arriba = 1'b0; abajo = 1'b0;
    rd_valid = 1'b0; rd_idx = 4'd0; rd_data = 8'h00; bus.wr_ack = 1'b0;
    test_reset();
    test_readback_hours();
    test_month_minutes();
    test_escritura_ignore();
    test_interr_drop();
    test_out_of_range();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
